// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle two's-complement subtractor, diff = a - b - bin.
// Resolves two bits per clock so no full-width borrow chain is ever built.
// Operands are captured on acceptance. The result appears after N/2 slice edges
// and is held stable until the consumer takes it.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int SLICES = N / 2;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  // Slices are two bits wide, so an odd or tiny width cannot be built.
  if (((N % 2) != 0) || (N < 2)) begin : g_bad_width
    $error("serial_subtractor: N must be even and >= 2");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [N-1:0]    work_q, work_d;
  logic            brw_q, brw_d;
  logic [N-1:0]    diff_q, diff_d;
  logic            bout_q, bout_d;
  logic            ovf_q, ovf_d;
  logic            out_valid_q, out_valid_d;

  logic            accept;
  logic            last_slice;
  logic [1:0]      a_sl, b_sl;
  logic [2:0]      slice_sum;
  logic            slice_brw;

  assign accept     = in_valid & in_ready;
  assign last_slice = (state_q == BUSY) && (cnt_q == LAST);

  // State, counter and visible result registers; all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
    end
  end

  // Working operands and partial difference; meaningful only inside an operation.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    brw_q  <= brw_d;
    work_q <= work_d;
  end

  // Next-state logic for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready only in IDLE and never while reset is held.
  always_comb begin
    in_ready = rst_n && (state_q == IDLE);
  end

  // Select the current slice. It is resolved as a + ~b + ~borrow, and the
  // inverted carry-out is the borrow passed on to the next slice.
  always_comb begin
    a_sl = 2'b00;
    b_sl = 2'b00;
    for (int k = 0; k < SLICES; k++) begin
      if (cnt_q == CW'(k)) begin
        a_sl = a_q[2*k +: 2];
        b_sl = b_q[2*k +: 2];
      end
    end
    slice_sum = {1'b0, a_sl} + {1'b0, ~b_sl} + {2'b00, ~brw_q};
    slice_brw = ~slice_sum[2];
  end

  // Datapath next values: capture, slice accumulation, and the final result load.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    brw_d       = brw_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    if (state_q == IDLE && accept) begin
      a_d   = a;
      b_d   = b;
      brw_d = bin;
      cnt_d = '0;
    end

    if (state_q == BUSY) begin
      brw_d = slice_brw;
      for (int k = 0; k < SLICES; k++) begin
        if (cnt_q == CW'(k)) work_d[2*k +: 2] = slice_sum[1:0];
      end
      cnt_d = last_slice ? '0 : cnt_q + CW'(1);
    end

    // Only the final slice edge publishes; partial slices stay internal.
    if (last_slice) begin
      diff_d      = work_d;
      bout_d      = slice_brw;
      ovf_d       = (a_q[N-1] ^ b_q[N-1]) & (work_d[N-1] ^ a_q[N-1]);
      out_valid_d = 1'b1;
    end

    if (state_q == DONE && out_valid_q && out_ready) out_valid_d = 1'b0;
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (N = 8).
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int checks;
  int failures;

  serial_subtractor #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accepting edge, then scramble the inputs.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
    a = ta;
    b = tb_v;
    bin = tbin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'hC3;
    b = 8'h3C;
    bin = ~tbin;
  endtask

  // Count edges after acceptance until out_valid; -1 if the budget runs out.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 8'h00;
    b = 8'h00;
    bin = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if ({diff, bout, ovf} !== 10'h000) begin failures++; $display("FAIL reset_outputs: got diff=%h bout=%b ovf=%b want 00/0/0", diff, bout, ovf); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_before: got %b want 1", in_ready); end
    start_op(8'h5A, 8'h23, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_busy_in_ready: got %b want 0", in_ready); end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
      checks++;
      if (diff !== 8'h00) begin failures++; $display("FAIL basic_no_partial: edge %0d got diff=%h want 00", i, diff); end
    end
    checks++;
    if (lat != 4) begin failures++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++;
    if ({diff, bout, ovf} !== {8'h37, 1'b0, 1'b0}) begin
      failures++; $display("FAIL basic_result: got diff=%h bout=%b ovf=%b want 37/0/0", diff, bout, ovf);
    end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_done_in_ready: got %b want 0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL basic_handshake: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vbin [5];
    logic [7:0] vd [5];
    logic       vbo [5];
    logic       vov [5];
    int lat;
    va[0] = 8'h00; vb[0] = 8'h01; vbin[0] = 1'b0; vd[0] = 8'hFF; vbo[0] = 1'b1; vov[0] = 1'b0;
    va[1] = 8'h80; vb[1] = 8'h01; vbin[1] = 1'b0; vd[1] = 8'h7F; vbo[1] = 1'b0; vov[1] = 1'b1;
    va[2] = 8'h7F; vb[2] = 8'hFF; vbin[2] = 1'b0; vd[2] = 8'h80; vbo[2] = 1'b1; vov[2] = 1'b1;
    va[3] = 8'h10; vb[3] = 8'h10; vbin[3] = 1'b1; vd[3] = 8'hFF; vbo[3] = 1'b1; vov[3] = 1'b0;
    va[4] = 8'h10; vb[4] = 8'h10; vbin[4] = 1'b0; vd[4] = 8'h00; vbo[4] = 1'b0; vov[4] = 1'b0;
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      start_op(va[v], vb[v], vbin[v]);
      wait_valid(lat);
      checks++;
      if (lat != 4) begin failures++; $display("FAIL vec%0d_latency: got %0d want 4", v, lat); end
      checks++;
      if ({diff, bout, ovf} !== {vd[v], vbo[v], vov[v]}) begin
        failures++;
        $display("FAIL vec%0d_result: got diff=%h bout=%b ovf=%b want %h/%b/%b", v, diff, bout, ovf, vd[v], vbo[v], vov[v]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++; $display("FAIL vec%0d_handshake: got out_valid=%b in_ready=%b want 0/1", v, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    start_op(8'h40, 8'h05, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL bp_latency: got %0d want 4", lat); end
    a = 8'h11;
    b = 8'h01;
    bin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, in_ready, diff, bout, ovf} !== {1'b1, 1'b0, 8'h3B, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold%0d: got out_valid=%b in_ready=%b diff=%h bout=%b ovf=%b want 1/0/3b/0/0",
                 i, out_valid, in_ready, diff, bout, ovf);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_handshake: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    a = 8'hC3;
    b = 8'h3C;
    bin = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_accept_next: got in_ready=%b want 0", in_ready); end
    wait_valid(lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL bp_next_latency: got %0d want 4", lat); end
    checks++;
    if ({diff, bout, ovf} !== {8'h10, 1'b0, 1'b0}) begin
      failures++; $display("FAIL bp_next_result: got diff=%h bout=%b ovf=%b want 10/0/0", diff, bout, ovf);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    out_ready = 1'b1;
    start_op(8'h5A, 8'h23, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready_low: got %b want 0", in_ready); end
    tick();
    checks++;
    if ({out_valid, diff, bout, ovf} !== 11'h000) begin
      failures++; $display("FAIL midrst_outputs: got out_valid=%b diff=%h bout=%b ovf=%b want 0/00/0/0", out_valid, diff, bout, ovf);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready_release: got %b want 1", in_ready); end
    start_op(8'h00, 8'h01, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL midrst_next_latency: got %0d want 4", lat); end
    checks++;
    if ({diff, bout, ovf} !== {8'hFF, 1'b1, 1'b0}) begin
      failures++; $display("FAIL midrst_next_result: got diff=%h bout=%b ovf=%b want ff/1/0", diff, bout, ovf);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
